// File: rtl/memory_arbiter_if.sv
// Requester and memory-bus signal bundle for memory_arbiter.
// The arbiter takes the slave view; requesters and the memory model take the master view.
interface memory_arbiter_if;
  logic        iIReq;
  logic [31:0] iIAddress;
  logic [31:0] oIReadData;
  logic        oIValid;
  logic        iDReq;
  logic        iDWrite;
  logic [3:0]  iDByteEnable;
  logic [31:0] iDAddress;
  logic [31:0] iDWriteData;
  logic [31:0] oDReadData;
  logic        oDValid;
  logic        oReadEnable;
  logic        oWriteEnable;
  logic [3:0]  oByteEnable;
  logic [31:0] oAddress;
  logic [31:0] oWriteData;
  logic [31:0] iReadData;
  logic        oBusy;

  modport slave (
    input  iIReq, iIAddress, iDReq, iDWrite, iDByteEnable, iDAddress, iDWriteData, iReadData,
    output oIReadData, oIValid, oDReadData, oDValid, oReadEnable, oWriteEnable, oByteEnable,
           oAddress, oWriteData, oBusy
  );

  modport master (
    output iIReq, iIAddress, iDReq, iDWrite, iDByteEnable, iDAddress, iDWriteData, iReadData,
    input  oIReadData, oIValid, oDReadData, oDValid, oReadEnable, oWriteEnable, oByteEnable,
           oAddress, oWriteData, oBusy
  );
endinterface

// File: rtl/memory_arbiter.sv
// Two-port (instruction fetch / data) arbiter onto a single memory bus, one access in flight.
// Conflicts resolve round-robin or with fixed data priority; bus outputs come from latched registers.
module memory_arbiter #(
  parameter int unsigned READ_LATENCY  = 2,
  parameter int unsigned DATA_PRIORITY = 0
) (
  input  logic             iCLK,
  input  logic             iRST,
  memory_arbiter_if.slave  bus
);

  localparam logic [3:0] LatLoad  = 4'(READ_LATENCY - 1);
  localparam bit         DataWins = (DATA_PRIORITY != 0);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e      state_q, state_d;
  logic        grant_i, grant_d;
  logic        owner_d_q;
  logic        last_d_q;
  logic        wr_q;
  logic [3:0]  cnt_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [31:0] irdata_q;
  logic [31:0] drdata_q;
  logic        access_last;

  // Writes finish after one ACCESS cycle; reads when the latency counter reaches zero.
  assign access_last = (state_q == StAccess) && (wr_q || (cnt_q == 4'd0));

  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state_q == StIdle) begin
      if (bus.iIReq && bus.iDReq) begin
        if (DataWins || !last_d_q) begin
          grant_d = 1'b1;
        end else begin
          grant_i = 1'b1;
        end
      end else begin
        grant_i = bus.iIReq;
        grant_d = bus.iDReq;
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (grant_i || grant_d) state_d = StAccess;
      StAccess: if (access_last) state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      owner_d_q <= 1'b0;
      last_d_q  <= 1'b0;
      wr_q      <= 1'b0;
      cnt_q     <= 4'd0;
      addr_q    <= 32'd0;
      be_q      <= 4'b0000;
      wdata_q   <= 32'd0;
      irdata_q  <= 32'd0;
      drdata_q  <= 32'd0;
    end else begin
      if (grant_i) begin
        addr_q    <= bus.iIAddress;
        be_q      <= 4'b1111;
        wr_q      <= 1'b0;
        owner_d_q <= 1'b0;
        last_d_q  <= 1'b0;
        cnt_q     <= LatLoad;
      end else if (grant_d) begin
        addr_q    <= bus.iDAddress;
        be_q      <= bus.iDByteEnable;
        wdata_q   <= bus.iDWriteData;
        wr_q      <= bus.iDWrite;
        owner_d_q <= 1'b1;
        last_d_q  <= 1'b1;
        cnt_q     <= bus.iDWrite ? 4'd0 : LatLoad;
      end else if ((state_q == StAccess) && (cnt_q != 4'd0)) begin
        cnt_q <= cnt_q - 4'd1;
      end

      if (access_last && !wr_q) begin
        if (owner_d_q) begin
          drdata_q <= bus.iReadData;
        end else begin
          irdata_q <= bus.iReadData;
        end
      end
    end
  end

  always_comb begin
    bus.oReadEnable  = 1'b0;
    bus.oWriteEnable = 1'b0;
    bus.oIValid      = 1'b0;
    bus.oDValid      = 1'b0;
    bus.oBusy        = (state_q != StIdle);
    unique case (state_q)
      StAccess: begin
        bus.oReadEnable  = !wr_q;
        bus.oWriteEnable = wr_q;
      end
      StResp: begin
        bus.oIValid = !owner_d_q;
        bus.oDValid = owner_d_q;
      end
      default: ;
    endcase
  end

  assign bus.oAddress   = addr_q;
  assign bus.oByteEnable = be_q;
  assign bus.oWriteData = wdata_q;
  assign bus.oIReadData = irdata_q;
  assign bus.oDReadData = drdata_q;

endmodule
